// File: rtl/nfc_bus_arbiter.sv
// Two-requester round-robin arbiter for one NAND flash port; runs a full
// page read or page program sequence on behalf of the granted requester.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req[1:0], op[1:0]   per-requester request and op (0 read, 1 program)
//   addr_0, addr_1      18-bit page/byte address per requester
//   wr_data_0/1         program data per requester
//   gnt                 one-hot grant held for the whole operation
//   rd_data, rd_valid   read byte stream to the granted requester
//   wr_ready            program byte taken for the current write cycle
//   op_done             one-cycle end-of-operation pulse
//   f_io_in/out/oe      flash IO bus (tri-state buffer is external)
//   f_cle, f_ale        command / address latch enables
//   f_ren, f_wen        read / write strobes, active-low
//   f_rb                flash ready/busy, 1 = ready
module nfc_bus_arbiter #(
    parameter int PAGE_BYTES = 512,
    parameter int RB_DLY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  op,
    input  logic [17:0] addr_0,
    input  logic [17:0] addr_1,
    input  logic [7:0]  wr_data_0,
    input  logic [7:0]  wr_data_1,
    output logic [1:0]  gnt,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        wr_ready,
    output logic        op_done,
    input  logic [7:0]  f_io_in,
    output logic [7:0]  f_io_out,
    output logic        f_io_oe,
    output logic        f_cle,
    output logic        f_ale,
    output logic        f_ren,
    output logic        f_wen,
    input  logic        f_rb
);
    localparam int CW = $clog2(PAGE_BYTES + 1);
    localparam int WW = $clog2(RB_DLY + 1);

    typedef enum logic [3:0] {
        IDLE, CMD_L, CMD_H, ADR_L, ADR_H, WAIT_RB,
        DATA_L, DATA_H, CONF_L, CONF_H, DONE
    } state_t;

    state_t        state, state_n;
    logic          sel, sel_n;
    logic          last, last_n;
    logic          prog, prog_n;
    logic          pick;
    logic [17:0]   addr_q, addr_n;
    logic [1:0]    acnt, acnt_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic [CW-1:0] bcnt, bcnt_n;
    logic [7:0]    wr_sel;

    logic [1:0] gnt_n;
    logic [7:0] rd_data_n, io_out_n;
    logic       rd_valid_n, wr_ready_n, op_done_n;
    logic       oe_n, cle_n, ale_n, ren_n, wen_n;

    assign wr_sel = sel ? wr_data_1 : wr_data_0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 1'b0;
            last     <= 1'b1;
            prog     <= 1'b0;
            addr_q   <= '0;
            acnt     <= '0;
            wcnt     <= '0;
            bcnt     <= '0;
            gnt      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_ready <= 1'b0;
            op_done  <= 1'b0;
            f_io_out <= '0;
            f_io_oe  <= 1'b0;
            f_cle    <= 1'b0;
            f_ale    <= 1'b0;
            f_ren    <= 1'b1;
            f_wen    <= 1'b1;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            last     <= last_n;
            prog     <= prog_n;
            addr_q   <= addr_n;
            acnt     <= acnt_n;
            wcnt     <= wcnt_n;
            bcnt     <= bcnt_n;
            gnt      <= gnt_n;
            rd_data  <= rd_data_n;
            rd_valid <= rd_valid_n;
            wr_ready <= wr_ready_n;
            op_done  <= op_done_n;
            f_io_out <= io_out_n;
            f_io_oe  <= oe_n;
            f_cle    <= cle_n;
            f_ale    <= ale_n;
            f_ren    <= ren_n;
            f_wen    <= wen_n;
        end
    end

    // Every flash pin is registered, so each branch computes the pin
    // values for the state being entered.
    always_comb begin
        state_n    = state;
        sel_n      = sel;
        last_n     = last;
        prog_n     = prog;
        pick       = 1'b0;
        addr_n     = addr_q;
        acnt_n     = acnt;
        wcnt_n     = wcnt;
        bcnt_n     = bcnt;
        gnt_n      = gnt;
        rd_data_n  = rd_data;
        rd_valid_n = 1'b0;
        wr_ready_n = 1'b0;
        op_done_n  = 1'b0;
        io_out_n   = f_io_out;
        oe_n       = 1'b0;
        cle_n      = 1'b0;
        ale_n      = 1'b0;
        ren_n      = 1'b1;
        wen_n      = 1'b1;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    pick     = (req == 2'b11) ? ~last : req[1];
                    sel_n    = pick;
                    prog_n   = op[pick];
                    addr_n   = pick ? addr_1 : addr_0;
                    gnt_n    = pick ? 2'b10 : 2'b01;
                    state_n  = CMD_L;
                    cle_n    = 1'b1;
                    wen_n    = 1'b0;
                    oe_n     = 1'b1;
                    io_out_n = op[pick] ? 8'h80 : {7'd0, addr_n[8]};
                end
            end
            CMD_L: begin
                state_n = CMD_H;
                cle_n   = 1'b1;
                oe_n    = 1'b1;
            end
            CMD_H: begin
                state_n  = ADR_L;
                acnt_n   = '0;
                ale_n    = 1'b1;
                wen_n    = 1'b0;
                oe_n     = 1'b1;
                io_out_n = addr_q[7:0];
            end
            ADR_L: begin
                state_n = ADR_H;
                ale_n   = 1'b1;
                oe_n    = 1'b1;
            end
            ADR_H: begin
                if (acnt == 2'd2) begin
                    wcnt_n = '0;
                    if (prog) begin
                        // Program data byte is taken on entry to DATA_L
                        // so it is stable for the whole WE-low phase.
                        state_n    = DATA_L;
                        wr_ready_n = 1'b1;
                        wen_n      = 1'b0;
                        oe_n       = 1'b1;
                        io_out_n   = wr_sel;
                    end else begin
                        state_n = WAIT_RB;
                    end
                end else begin
                    acnt_n   = acnt + 2'd1;
                    state_n  = ADR_L;
                    ale_n    = 1'b1;
                    wen_n    = 1'b0;
                    oe_n     = 1'b1;
                    io_out_n = (acnt == 2'd0) ? addr_q[16:9]
                                              : {7'd0, addr_q[17]};
                end
            end
            WAIT_RB: begin
                // f_rb is first looked at RB_DLY cycles after the last
                // write strobe; earlier it may not have dropped yet.
                if (wcnt < WW'(RB_DLY - 1)) begin
                    wcnt_n = wcnt + WW'(1);
                end else if (f_rb) begin
                    wcnt_n = '0;
                    if (prog) begin
                        state_n   = DONE;
                        op_done_n = 1'b1;
                        gnt_n     = '0;
                        last_n    = sel;
                    end else begin
                        state_n = DATA_L;
                        ren_n   = 1'b0;
                    end
                end
            end
            DATA_L: begin
                state_n = DATA_H;
                if (prog) begin
                    oe_n = 1'b1;
                end else begin
                    rd_data_n  = f_io_in;
                    rd_valid_n = 1'b1;
                end
            end
            DATA_H: begin
                if (bcnt == CW'(PAGE_BYTES - 1)) begin
                    bcnt_n = '0;
                    if (prog) begin
                        state_n  = CONF_L;
                        cle_n    = 1'b1;
                        wen_n    = 1'b0;
                        oe_n     = 1'b1;
                        io_out_n = 8'h10;
                    end else begin
                        state_n   = DONE;
                        op_done_n = 1'b1;
                        gnt_n     = '0;
                        last_n    = sel;
                    end
                end else begin
                    bcnt_n  = bcnt + CW'(1);
                    state_n = DATA_L;
                    if (prog) begin
                        wr_ready_n = 1'b1;
                        wen_n      = 1'b0;
                        oe_n       = 1'b1;
                        io_out_n   = wr_sel;
                    end else begin
                        ren_n = 1'b0;
                    end
                end
            end
            CONF_L: begin
                state_n = CONF_H;
                cle_n   = 1'b1;
                oe_n    = 1'b1;
            end
            CONF_H: begin
                state_n = WAIT_RB;
                wcnt_n  = '0;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: doc/nfc_bus_arbiter.md
Name: nfc_bus_arbiter

Overview:
- Shares one NAND flash port between two requesters, such as a page-copy engine and a host/patch engine.
- Each requester asks for a full-page read or a full-page program.
- The block grants round-robin, then runs the whole flash sequence itself: command byte, 3 address cycles, RB wait, a PAGE_BYTES-byte data phase, and for programs the 10h confirm plus RB wait.
- It sits between the requesters and the F_IO/F_CLE/F_ALE/F_REN/F_WEN/F_RB pins; the tri-state buffer is outside the block.

Parameters:
- PAGE_BYTES, 512, bytes moved per data phase.
- RB_DLY, 2, cycles after the last command/address/confirm write before f_rb is sampled (tWB guard).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req  in  2  request per requester; bit i = requester i.
- op  in  2  op[i]: 0 = page read, 1 = page program.
- addr_0  in  18  page/byte address of requester 0.
- addr_1  in  18  page/byte address of requester 1.
- wr_data_0  in  8  program data from requester 0.
- wr_data_1  in  8  program data from requester 1.
- gnt  out  2  one-hot grant, held for the whole operation.
- rd_data  out  8  read byte.
- rd_valid  out  1  rd_data valid; goes to the granted requester.
- wr_ready  out  1  the block latches wr_data_<granted> at this clock edge.
- op_done  out  1  one-cycle pulse at the end of the operation.
- f_io_in  in  8  flash IO input.
- f_io_out  out  8  flash IO drive value.
- f_io_oe  out  1  IO output enable.
- f_cle  out  1  command latch enable.
- f_ale  out  1  address latch enable.
- f_ren  out  1  read enable, active-low.
- f_wen  out  1  write enable, active-low.
- f_rb  in  1  ready/busy; 1 = ready.

Behaviour:
- Reset values:
  - State IDLE; round-robin pointer set so requester 0 wins first.
  - gnt = 0, rd_valid = 0, wr_ready = 0, op_done = 0.
  - f_cle = 0, f_ale = 0, f_io_oe = 0, f_io_out = 0, f_ren = 1, f_wen = 1.
  - A reset mid-operation aborts immediately with no flash cleanup.
- All flash outputs are registered. No clock gating onto f_wen or f_ren.

Arbitration (IDLE only):
- If one req is set, grant it.
- If both are set, grant the requester not granted last.
- gnt asserts in the cycle after the IDLE decision.
- The requester holds req, op and addr stable until op_done; the block ignores their changes while busy.

Write cycles:
- Each byte written to the flash takes 2 cycles: _L (f_wen = 0, f_io_oe = 1, byte on f_io_out), then _H (f_wen = 1, same byte held).

Sequence:
1. CMD_L/H: f_cle = 1.
   - Read: byte = {7'd0, addr[8]}, i.e. 00h or 01h.
   - Program: byte = 80h.
2. ADR_L/H ×3: f_ale = 1. Bytes are addr[7:0], then addr[16:9], then {7'd0, addr[17]}.
3. Read: WAIT_RB.
   - Wait RB_DLY cycles, then stay until f_rb = 1.
   - DATA_L: f_ren = 0.
   - DATA_H: f_ren = 1.
   - rd_data is registered from f_io_in at the DATA_L→DATA_H edge; rd_valid = 1 during DATA_H.
   - Repeat PAGE_BYTES times, then go to DONE.
4. Program: DATA_L/H write cycles.
   - wr_ready = 1 in DATA_L; the byte is latched at that edge and driven during DATA_L/H.
   - Repeat PAGE_BYTES times.
   - Then CONF_L/H: f_cle = 1, byte = 10h.
   - Then WAIT_RB (RB_DLY cycles, then f_rb = 1), then DONE.
5. DONE: op_done = 1 for one cycle; gnt drops in the same cycle; pointer updates; return to IDLE.
   - A new grant is possible in the next cycle.

Counters and boundaries:
- The byte counter is wide enough for PAGE_BYTES and wraps to 0 on exit.
- f_rb = 0 for an unbounded time: remain in WAIT_RB, with no timeout.
- f_rb = 1 already during the RB_DLY window: ignored; sampling starts only after the window.
- A req deasserted mid-operation has no effect; the operation completes.
- Both requests arriving in the same cycle as DONE: arbitration happens in the following IDLE cycle.

Test Plan:
- req = 01, op_0 = 0, addr_0 = 18'h001FF:
  - Flash writes are 01h with cle, then FFh, 00h, 00h with ale.
  - f_rb held low 10 cycles → no f_ren activity.
  - Then exactly 512 rd_valid pulses with data matching the flash model, op_done once, gnt = 01 throughout.
- req = 10, op_1 = 1, addr_1 = 18'h3FFFF:
  - Writes are 80h, FFh, FFh, 01h.
  - 512 wr_ready pulses with bytes matching wr_data_1.
  - Then 10h with cle, the RB wait, and op_done.
- Both requesting continuously:
  - Grants alternate 01, 10, 01, 10 across 4 operations.
  - No cycle has gnt = 11; op_done count = 4.
- f_rb = 1 constant:
  - The first f_rb sample occurs exactly RB_DLY cycles after the last ADR_H (read) or CONF_H (program).
- Reset asserted during a program data phase at byte 100:
  - All outputs return to reset values asynchronously.
  - After release with req = 11, requester 0 is granted first.
- Protocol checker throughout:
  - cle and ale never both high.
  - f_ren and f_wen never both low.
  - f_io_oe = 0 whenever f_ren = 0.
